alu_issue_stage: RTL and testbench

//  Operand-fetch / issue / write-back sequencer for the 32-bit ALU. Accepts one instruction per

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_regfile.sv | 40 ++++
 rtl/alu_issue_stage.sv | 140 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, sequencer states and the flag word.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_AND = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
    } flags_t;

    // True for the three opcodes the ALU actually implements.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SLL) || (op == ALU_AND);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x XLEN register file: three async read ports, one sync write port,
// synchronous active-low clear, register 0 hardwired to zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic [AW-1:0]   raddr_dbg,
    output logic [XLEN-1:0] rdata_dbg
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Clear on reset; writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == '0) ? '0 : mem_q[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : mem_q[raddr_b];
    assign rdata_dbg = (raddr_dbg == '0) ? '0 : mem_q[raddr_dbg];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch / issue / write-back sequencer for the 32-bit ALU.
// IDLE captures operands, EXEC lets the ALU settle, WB writes rd and the flags.
// Optional: define ALU_ISSUE_OPCHECK_EN to reject unknown opcodes with an err pulse.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_imm,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [XLEN-1:0] alu_d,
    input  logic            alu_cout,
    input  logic            alu_v,
    input  logic            alu_z,
    output logic            res_valid,
    output logic [AW-1:0]   res_rd,
    output logic [XLEN-1:0] res_data,
    output logic [2:0]      flags,
`ifdef ALU_ISSUE_OPCHECK_EN
    output logic            err,
`endif
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    issue_state_t    state_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [2:0]      alu_op_q;
    logic [AW-1:0]   rd_q;
    logic            res_valid_q;
    logic [AW-1:0]   res_rd_q;
    logic [XLEN-1:0] res_data_q;
    flags_t          flags_q;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            wb_legal;
    logic            rf_we;
    flags_t          wb_flags;

`ifdef ALU_ISSUE_OPCHECK_EN
    logic err_q;
    assign err      = err_q;
    assign wb_legal = op_is_legal(alu_op_q);
`else
    assign wb_legal = 1'b1;
`endif

    // Overflow is only meaningful for add; the ALU may drive X otherwise.
    assign wb_flags = '{c: alu_cout, v: (alu_op_q == ALU_ADD) ? alu_v : 1'b0, z: alu_z};
    assign rf_we    = (state_q == WB) && wb_legal;

    alu_regfile #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (rf_we),
        .waddr     (rd_q),
        .wdata     (alu_d),
        .raddr_a   (in_rs1),
        .rdata_a   (rs1_data),
        .raddr_b   (in_rs2),
        .rdata_b   (rs2_data),
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
    );

    // Sequencer with operand capture and registered write-back outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            res_valid_q <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            flags_q     <= '0;
`ifdef ALU_ISSUE_OPCHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            res_valid_q <= 1'b0;
`ifdef ALU_ISSUE_OPCHECK_EN
            err_q       <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q  <= rs1_data;
                        alu_b_q  <= in_use_imm ? in_imm : rs2_data;
                        alu_op_q <= in_op;
                        rd_q     <= in_rd;
                        state_q  <= EXEC;
                    end
                end
                EXEC: state_q <= WB;
                WB: begin
                    state_q <= IDLE;
                    if (wb_legal) begin
                        res_valid_q <= 1'b1;
                        res_rd_q    <= rd_q;
                        res_data_q  <= alu_d;
                        flags_q     <= wb_flags;
                    end
`ifdef ALU_ISSUE_OPCHECK_EN
                    else begin
                        err_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU on the alu_* ports.
// The ALU shifter uses b[2:0] as shift amount. Honours ALU_ISSUE_OPCHECK_EN.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic          clk, rst_n;
    logic          in_valid, in_ready, in_use_imm;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2, res_rd, dbg_addr;
    logic [31:0]   in_imm, alu_a, alu_b, alu_d, res_data, dbg_data;
    logic [2:0]    alu_op, flags;
    logic          alu_cout, alu_v, alu_z, res_valid;
`ifdef ALU_ISSUE_OPCHECK_EN
    logic          err;
`endif

    alu_issue_stage #(.NREGS(NREGS), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_d(alu_d),
        .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z), .res_valid(res_valid),
        .res_rd(res_rd), .res_data(res_data), .flags(flags),
`ifdef ALU_ISSUE_OPCHECK_EN
        .err(err),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; overflow is X for non-add ops.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_cout = 1'b0;
        alu_v    = 1'bx;
        case (alu_op)
            3'b000: begin
                alu_d    = alu_sum[31:0];
                alu_cout = alu_sum[32];
                alu_v    = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            3'b001:  alu_d = alu_a << alu_b[2:0];
            3'b111:  alu_d = alu_a & alu_b;
            default: alu_d = alu_a ^ alu_b;
        endcase
        alu_z = (alu_d == 32'h0);
    end

    typedef struct {
        logic [AW-1:0] rd;
        logic [31:0]   data;
        logic [2:0]    flags;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_r [NREGS];
    logic [2:0]  model_flags;
    int          checks = 0;
    int          errors = 0;

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model_r[i] = 32'h0;
        model_flags = 3'b000;
    endtask

    // Predict one instruction, push its result, and update the reference state.
    task automatic push_expect(input logic [2:0] op, input logic [AW-1:0] rd,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic use_imm, input logic [31:0] imm);
        logic [31:0] a, b, d;
        logic [32:0] s;
        logic        c, v;
        exp_t        e;
        a = model_r[rs1];
        b = use_imm ? imm : model_r[rs2];
        s = {1'b0, a} + {1'b0, b};
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                d = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (d[31] != a[31]);
            end
            3'b001:  d = a << b[2:0];
            3'b111:  d = a & b;
            default: d = a ^ b;
        endcase
`ifdef ALU_ISSUE_OPCHECK_EN
        if (!(op == 3'b000 || op == 3'b001 || op == 3'b111)) return;
`endif
        e.rd    = rd;
        e.data  = d;
        e.flags = {c, v, (d == 32'h0)};
        sb_q.push_back(e);
        if (rd != 0) model_r[rd] = d;
        model_flags = e.flags;
    endtask

    // Scoreboard: every write-back pulse pops one prediction.
    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_res_valid got rd=%0d data=%h, required no pulse",
                         res_rd, res_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (res_rd !== mon_e.rd) begin
                    errors++;
                    $display("FAIL res_rd got %0d required %0d", res_rd, mon_e.rd);
                end
                checks++;
                if (res_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL res_data got %h required %h", res_data, mon_e.data);
                end
                checks++;
                if (flags !== mon_e.flags) begin
                    errors++;
                    $display("FAIL flags got %b required %b", flags, mon_e.flags);
                end
            end
        end
    end

    // One full transaction with latency, ready and debug-port checks.
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic use_imm, input logic [31:0] imm);
        int          lat;
        logic [31:0] old;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_use_imm = use_imm; in_imm = imm; in_valid = 1'b1;
        dbg_addr = rd;
        old = model_r[rd];
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle got %b required 1", in_ready);
        end
        push_expect(op, rd, rs1, rs2, use_imm, imm);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_exec got %b required 0", in_ready);
        end
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (dbg_data !== old) begin
                    errors++;
                    $display("FAIL dbg_in_wb got %h required %h", dbg_data, old);
                end
            end
            if (res_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency got %0d required 2", lat);
        end
        checks++;
        if (dbg_data !== model_r[rd]) begin
            errors++;
            $display("FAIL dbg_after_wb got %h required %h", dbg_data, model_r[rd]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_imm = 1'b0; in_imm = 32'h0; dbg_addr = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", in_ready);
        end
        checks++;
        if (flags !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b required 000", flags);
        end
        for (int i = 0; i < NREGS; i++) begin
            dbg_addr = AW'(i);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg r%0d got %h required 0", i, dbg_data);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_imm();
        issue(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF);
        issue(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 32'h0000_0001);
        checks++;
        if (dbg_data !== 32'h8000_0000) begin
            errors++;
            $display("FAIL add_r2 got %h required 80000000", dbg_data);
        end
        checks++;
        if (flags !== 3'b010) begin
            errors++;
            $display("FAIL add_flags got %b required 010", flags);
        end
    endtask

    task automatic test_shift();
        issue(3'b000, 3'd3, 3'd0, 3'd0, 1'b1, 32'h1);
        issue(3'b001, 3'd4, 3'd3, 3'd0, 1'b1, 32'd4);
        checks++;
        if (dbg_data !== 32'h10 || flags[1] !== 1'b0) begin
            errors++;
            $display("FAIL sll4 got %h/%b required 00000010/V0", dbg_data, flags);
        end
        issue(3'b001, 3'd4, 3'd3, 3'd0, 1'b1, 32'd40);
        checks++;
        if (dbg_data !== 32'h1) begin
            errors++;
            $display("FAIL sll40 got %h required 00000001", dbg_data);
        end
    endtask

    task automatic test_and_zero();
        issue(3'b000, 3'd5, 3'd0, 3'd0, 1'b1, 32'hF0);
        issue(3'b111, 3'd5, 3'd5, 3'd0, 1'b1, 32'h0F);
        checks++;
        if (dbg_data !== 32'h0 || flags[0] !== 1'b1) begin
            errors++;
            $display("FAIL and_zero got %h/%b required 00000000/Z1", dbg_data, flags);
        end
        issue(3'b000, 3'd0, 3'd2, 3'd1, 1'b0, 32'h0);
        checks++;
        if (dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL r0_write got %h required 0", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] hs_mask;
        int         pulses;
        hs_mask = '0;
        @(negedge clk);
        in_op = 3'b000; in_rd = 3'd6; in_rs1 = 3'd6; in_rs2 = 3'd0;
        in_use_imm = 1'b1; in_imm = 32'h1; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (in_ready === 1'b1) begin
                hs_mask[c] = 1'b1;
                push_expect(3'b000, 3'd6, 3'd6, 3'd0, 1'b1, 32'h1);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (hs_mask !== 10'b10_0100_1001) begin
            errors++;
            $display("FAIL handshake_slots got %b required 1001001001", hs_mask);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drained got %0d pending required 0", sb_q.size());
        end
        // Abort an instruction by resetting while it sits in EXEC.
        in_op = 3'b000; in_rd = 3'd7; in_rs1 = 3'd6; in_use_imm = 1'b1; in_imm = 32'h99;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_res_valid got %0d pulses required 0", pulses);
        end
        dbg_addr = 3'd7;
        #1;
        checks++;
        if (dbg_data !== 32'h0 || flags !== 3'b000) begin
            errors++;
            $display("FAIL abort_state got %h/%b required 0/000", dbg_data, flags);
        end
    endtask

    task automatic test_opcheck();
        issue(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 32'h55);
        issue(3'b000, 3'd2, 3'd0, 3'd0, 1'b1, 32'h0F);
`ifdef ALU_ISSUE_OPCHECK_EN
        begin
            int lat;
            @(negedge clk);
            in_op = 3'b010; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
            in_use_imm = 1'b0; in_valid = 1'b1; dbg_addr = 3'd3;
            push_expect(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0);
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            for (int i = 1; i <= 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (err === 1'b1) begin
                    lat = i;
                    break;
                end
            end
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL err_latency got %0d required 2", lat);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (dbg_data !== model_r[3] || flags !== model_flags) begin
                errors++;
                $display("FAIL err_no_update got %h/%b required %h/%b",
                         dbg_data, flags, model_r[3], model_flags);
            end
        end
`else
        issue(3'b010, 3'd3, 3'd1, 3'd2, 1'b0, 32'h0);
        checks++;
        if (dbg_data !== 32'h5A) begin
            errors++;
            $display("FAIL op010_passthru got %h required 0000005a", dbg_data);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_shift();
        test_and_zero();
        test_back_to_back();
        test_opcheck();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
